// File: rtl/float_decoder_if.sv
// Valid/ready bundle between the float decoder and its producer/consumer.
// The slave modport is the decoder side; the master modport is the surrounding datapath.
interface float_decoder_if;
  logic [7:0]  fp_in;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] result;
  logic        out_valid;
  logic        out_ready;

  modport slave (
    input  fp_in, in_valid, out_ready,
    output in_ready, result, out_valid
  );

  modport master (
    output fp_in, in_valid, out_ready,
    input  in_ready, result, out_valid
  );
endinterface

// File: rtl/float_decoder.sv
// Iterative decoder from the 8-bit float code (S, E[2:0], F[3:0]) to a 12-bit
// two's-complement integer: one operand in flight, one shift per cycle.
module float_decoder (
  input  logic            clk,
  input  logic            rst,
  float_decoder_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]  state;
  logic        sign_r;
  logic [10:0] mag;
  logic [2:0]  cnt;
  logic [11:0] result_r;
  logic        out_valid_r;

  // in_ready is decoded straight from the state, so it reads 1 during reset;
  // the reset branch below still takes priority over any handshake.
  assign bus.in_ready  = (state == IDLE);
  assign bus.result    = result_r;
  assign bus.out_valid = out_valid_r;

  // NOTE: every register here is updated with <= so all reads within a cycle
  // see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sign_r      <= 1'b0;
      mag         <= '0;
      cnt         <= '0;
      result_r    <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign_r <= bus.fp_in[7];
            mag    <= {7'b0, bus.fp_in[3:0]};
            cnt    <= bus.fp_in[6:4];
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != 3'd0) begin
            mag <= mag << 1;
            cnt <= cnt - 3'd1;
          end else begin
            // Magnitude tops out at 1920, so the widened negate never overflows;
            // negative zero wraps back to 12'h000.
            result_r    <= sign_r ? (~{1'b0, mag} + 12'd1) : {1'b0, mag};
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_decoder.sv
// Directed and exhaustive checks of float_decoder: latency, sign handling,
// backpressure, mid-operation reset and a full 256-code sweep with stalls.
module tb_float_decoder;

  logic clk = 1'b0;
  logic rst;

  float_decoder_if bus ();

  float_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;
  int rises     = 0;
  int exp_rises = 0;
  logic ov_prev = 1'b0;

  typedef struct {
    logic [7:0]  fp;
    logic [11:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [6] = '{
    '{8'h00, 12'h000, 1},
    '{8'h7F, 12'h780, 8},
    '{8'hFF, 12'h880, 8},
    '{8'h39, 12'h048, 4},
    '{8'hAB, 12'hFD4, 3},
    '{8'h80, 12'h000, 1}
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: (-1)^S * F * 2^E, truncated to 12 bits.
  function automatic logic [11:0] ref_val(input logic [7:0] fp);
    int m;
    int v;
    m = int'(fp[3:0]) << fp[6:4];
    v = fp[7] ? -m : m;
    return v[11:0];
  endfunction

  // Count rising edges of out_valid, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && ov_prev !== 1'b1) rises++;
    ov_prev = bus.out_valid;
  end

  // Drive one operand from a negedge, then wait (bounded) for out_valid.
  // lat = number of rising edges after the accept edge until out_valid is high.
  task automatic send(input logic [7:0] fp, output int lat);
    check("pre_rdy", 32'(bus.in_ready), 32'd1);
    bus.fp_in    = fp;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    exp_rises++;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic seen;
    logic pend;
    logic fin;
    logic [11:0] r;

    // Reset with a handshake offered: it must be ignored.
    rst           = 1'b1;
    bus.fp_in     = 8'h01;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ov",  32'(bus.out_valid), 32'd0);
    check("rst_res", 32'(bus.result),    32'h000);
    check("rst_rdy", 32'(bus.in_ready),  32'd1);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_hs_ignored_rdy", 32'(bus.in_ready),  32'd1);
    check("rst_hs_ignored_ov",  32'(bus.out_valid), 32'd0);

    // Directed vectors with out_ready tied high.
    foreach (vecs[i]) begin
      send(vecs[i].fp, lat);
      check("dir_res", 32'(bus.result), 32'(vecs[i].exp));
      check("dir_lat", 32'(lat),        32'(vecs[i].lat));
      @(negedge clk);
      check("dir_drop", 32'(bus.out_valid), 32'd0);
      check("dir_idle", 32'(bus.in_ready),  32'd1);
    end

    // Backpressure: result must hold while in_valid and fp_in churn.
    bus.out_ready = 1'b0;
    send(8'h13, lat);
    check("bp_res", 32'(bus.result), 32'h006);
    check("bp_lat", 32'(lat),        32'd2);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.fp_in    = (i % 2 == 1) ? 8'hFF : 8'h7F;
      @(negedge clk);
      check("bp_hold_res", 32'(bus.result),    32'h006);
      check("bp_hold_ov",  32'(bus.out_valid), 32'd1);
      check("bp_hold_rdy", 32'(bus.in_ready),  32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_drop", 32'(bus.out_valid), 32'd0);
    check("bp_idle", 32'(bus.in_ready),  32'd1);
    repeat (3) begin
      @(negedge clk);
      check("bp_no_accept", 32'(bus.in_ready), 32'd1);
    end

    // Reset in the middle of SHIFT discards the operand.
    check("mid_pre_rdy", 32'(bus.in_ready), 32'd1);
    bus.fp_in    = 8'h78;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mid_busy", 32'(bus.in_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_res", 32'(bus.result),   32'h000);
    check("mid_rdy", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    check("mid_no_ov", 32'(seen), 32'd0);
    send(8'h05, lat);
    check("mid_fresh_res", 32'(bus.result), 32'h005);
    check("mid_fresh_lat", 32'(lat),        32'd1);
    @(negedge clk);
    check("mid_fresh_drop", 32'(bus.out_valid), 32'd0);

    // Exhaustive sweep with random consumer stalls.
    for (int code = 0; code < 256; code++) begin
      r = ref_val(8'(code));
      check("sw_rdy", 32'(bus.in_ready), 32'd1);
      bus.fp_in     = 8'(code);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'($urandom_range(0, 1));
      exp_rises++;
      pend = 1'b0;
      fin  = 1'b0;
      for (int k = 0; k < 60 && !fin; k++) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (pend) begin
          check("sw_drop", 32'(bus.out_valid), 32'd0);
          fin = 1'b1;
        end else begin
          if (bus.out_valid === 1'b1) check("sw_res", 32'(bus.result), 32'(r));
          bus.out_ready = 1'($urandom_range(0, 1));
          if (bus.out_valid === 1'b1 && bus.out_ready) pend = 1'b1;
        end
      end
      check("sw_done", 32'(fin), 32'd1);
    end
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("transfers_per_accept", 32'(rises), 32'(exp_rises));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/float_decoder.md
# float_decoder

Multi-cycle decoder converting the 8-bit floating-point format (1 sign bit, 3-bit exponent, 4-bit significand, value = significand × 2^exponent) back into a 12-bit two's-complement integer. It is the inverse of the 12-bit-to-float conversion path, whose front end is the sign/magnitude split stage. The block sits downstream of the float encoder in the lab datapath and provides the round-trip check. It uses a valid/ready handshake on both sides and processes one operand at a time with an iterative shifter.

## Interface
- No parameters; all widths are fixed by the float format.
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- fp_in  in  8  operand: [7] sign, [6:4] exponent E, [3:0] significand F.
- in_valid  in  1  fp_in is valid.
- in_ready  out  1  decoder can accept; combinational, equals (state == IDLE).
- result  out  12  two's-complement output, registered.
- out_valid  out  1  result is valid, registered.
- out_ready  in  1  consumer accepts result.

## Operation
- States: IDLE, SHIFT, DONE. Registers: sign_r (1), mag (11), cnt (3), result (12), out_valid.
- IDLE: in_ready=1. On in_valid && in_ready: sign_r<=fp_in[7], mag<={7'b0,F}, cnt<=E, state<=SHIFT. Otherwise hold.
- SHIFT: if cnt != 0: mag<=mag<<1, cnt<=cnt-1. If cnt == 0: result<=sign_r ? (~{1'b0,mag}+1) : {1'b0,mag}, out_valid<=1, state<=DONE.
- DONE: result and out_valid held stable. On out_ready: out_valid<=0, state<=IDLE.
- Arithmetic: the maximum magnitude is 15<<7 = 1920, which fits in 11 bits, so no overflow is possible. The negative range bottoms at -1920 (12'h880); -2048 is never produced.
- Negative zero (sign=1, F=0) yields 12'h000.
- Denormalised inputs (F[3]=0 with E>0) are decoded literally as F<<E. No error flag is raised.
- in_valid outside IDLE is ignored. fp_in is sampled only at the accepting edge, and later changes have no effect.
- Reset (any state, including mid-SHIFT or DONE): state<=IDLE, out_valid<=0, result<=12'h000, mag<=0, cnt<=0, sign_r<=0. An in-flight operand is discarded with no output.
- Handshakes while rst=1 are ignored, even though in_ready reads 1.

## Timing
- Accept edge = rising edge where in_valid && in_ready && !rst.
- SHIFT lasts E+1 cycles. out_valid rises at the (E+1)th edge after the accept edge, so latency ranges from 1 edge (E=0) to 8 edges (E=7).
- Transfer completes at the first edge with out_valid && out_ready. in_ready is 1 in the following cycle.
- Minimum spacing between accept edges is E+3 cycles with out_ready tied high. There is no overlap or pipelining.
- out_valid, once high, never drops without out_ready or rst.

## Test plan
- Reset, then fp_in=8'b0_000_0000 with in_valid pulse, out_ready=1 -> result=12'h000 and out_valid high 1 edge after accept, low the edge after.
- fp_in=8'b0_111_1111 -> result=12'h780 (1920), out_valid rising 8 edges after accept. fp_in=8'b1_111_1111 -> result=12'h880 (-1920).
- fp_in=8'b0_011_1001 -> 12'h048 (72). fp_in=8'b1_010_1011 -> 12'hFD4 (-44). fp_in=8'b1_000_0000 -> 12'h000.
- Backpressure: decode 8'b0_001_0011 (expect 12'h006) with out_ready=0 for 5 cycles while in_valid=1 and fp_in toggles -> result and out_valid stable, in_ready=0, no new accept. Raise out_ready -> one transfer, then IDLE.
- Reset mid-operation: accept 8'b0_111_1000, assert rst for 1 cycle after 3 SHIFT cycles -> out_valid never rises, result=12'h000, in_ready=1 after rst. A fresh 8'b0_000_0101 then yields 12'h005.
- Exhaustive sweep of all 256 codes against the reference model ((-1)^S × F × 2^E), with random out_ready stalls -> every result matches, and exactly one out_valid transfer occurs per accept.
